cs_channel_arbiter: RTL and testbench
=====================================

Name: cs_channel_arbiter

Overview:
Round-robin arbiter that shares one coherent-sampler consumer between NBChannels COSO instances. The consumer is a matching controller or a bit extractor. Each COSO coherent sampler presents a counter value with a req/ack handshake. The arbiter grants one channel, registers its counter and forwards it on a single req/ack port. It returns the consumer's ack to the granted channel. It sits between the per-channel coherent samplers and the single downstream consumer.

Parameters:
NBChannels, 4, number of coherent-sampler channels (>=2)
NBChanLog, 2, width of channel index; 2^NBChanLog >= NBChannels
CSCntLength, 16, coherent sampler counter width
TimeoutLog, 8, ack timeout = 2^TimeoutLog clock cycles

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
chanEn  in  NBChannels  per-channel enable mask; a 0 bit excludes that channel from new grants
CSCntIn  in  NBChannels*CSCntLength  channel i counter at bits [i*CSCntLength +: CSCntLength]
CSReqIn  in  NBChannels  per-channel request, level, held until acked
CSAckOut  out  NBChannels  per-channel acknowledge, one-cycle pulse
CSCnt  out  CSCntLength  registered counter of the granted channel
CSReq  out  1  request to consumer
CSAck  in  1  consumer acknowledge, one-cycle pulse
chanSel  out  NBChanLog  index of the current or last granted channel
busy  out  1  high in every state except IDLE
timeout  out  1  sticky flag: consumer failed to ack within 2^TimeoutLog cycles

Behaviour:
- Clock and reset: one clock, clk. Reset rstN is asynchronous and active-low.
- Reset values: CSAckOut=0, CSCnt=0, CSReq=0, chanSel=0, busy=0, timeout=0, rrPtr=0, state=IDLE, timer=0.
- Reset mid-transaction aborts immediately. No ack is sent to the channel.
- States: IDLE, REQ, ACK, DROP.
- IDLE:
  - Eligible channels are those with CSReqIn[i] & chanEn[i].
  - Pick the first eligible index scanning rrPtr, rrPtr+1, ..., wrapping modulo NBChannels.
  - If one is found: CSCnt <= CSCntIn[g], chanSel <= g, CSReq <= 1, timer <= 0, go to REQ.
  - Grant latency: CSReqIn rising in cycle t with arbiter idle gives CSReq=1 at t+1.
- REQ:
  - CSReq held high; timer increments each cycle.
  - If CSAck=1: CSReq <= 0, CSAckOut[chanSel] <= 1, go to ACK.
  - Else if timer == 2^TimeoutLog-1: CSReq <= 0, timeout <= 1, CSAckOut[chanSel] <= 1, go to ACK. The channel is released, not deadlocked.
- ACK:
  - CSAckOut pulse lasts exactly one cycle; cleared here. Go to DROP.
- DROP:
  - Wait until CSReqIn[chanSel]=0, then rrPtr <= chanSel+1 (wrapping to 0 past NBChannels-1) and go to IDLE.
  - A channel is never re-granted from the same request level.
- CSAck received outside REQ is ignored.
- Changes to chanEn or to a channel's CSCntIn during REQ/ACK/DROP do not affect the current transaction. CSCnt is frozen from grant to the next grant.
- Simultaneous requests: strict round-robin from rrPtr. With all channels requesting continuously, grant order is 0,1,2,3,0,...
- timeout is cleared only by reset.
- No combinational path from any input to any output; all outputs are registered.
- Minimum cycle per transaction: 4 clocks (IDLE, REQ with immediate ack, ACK, DROP with request already low).

Decomposition:
- Shared package (cs_pkg): state encoding constants (IDLE/REQ/ACK/DROP) and the default CSCntLength.
- One natural sub-module: rr_priority_pick.
  - Combinational rotate-and-priority-encode.
  - Inputs: request vector and rrPtr. Outputs: found flag and index.
  - Reusable by other arbiters in the TRNG.

Test Plan:
- Single channel 2 requests with CSCntIn[2]=16'h1234, consumer acks 3 cycles after CSReq -> CSReq=1 one cycle later with CSCnt=16'h1234, chanSel=2; CSAckOut=4'b0100 for exactly one cycle; busy falls after CSReqIn[2] drops.
- All 4 channels request continuously, consumer acks after 1 cycle, each channel drops its request 1 cycle after its ack -> grants in order 0,1,2,3,0,1; no channel granted twice in a row.
- chanEn=4'b1010 with all requesting -> only channels 1 and 3 granted, alternating; clearing chanEn[1] during its REQ still completes that transaction.
- Consumer never acks, TimeoutLog=4 -> CSReq drops after 16 cycles in REQ; timeout=1 and stays 1; CSAckOut pulses for the granted channel; next channel is granted afterwards.
- Channel holds CSReqIn high for 10 cycles after its ack -> arbiter stays in DROP with busy=1; no second grant to that channel; then proceeds to IDLE.
- rstN pulled low during REQ -> CSReq, CSAckOut, busy, timeout, chanSel all 0 asynchronously; after release, the first grant goes to the lowest eligible index from 0.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared definitions for the coherent-sampler channel arbiter: FSM states,
// default counter width and a small index helper.
package cs_pkg;

  localparam int CS_CNT_LENGTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_DROP = 2'd3
  } arb_state_t;

  // Next channel index after idx, wrapping to 0 past n-1.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cs_channel_arbiter_if.sv
// Channel-side and consumer-side handshake bundle of the arbiter.
// master = environment (samplers + consumer), slave = arbiter.
interface cs_channel_arbiter_if import cs_pkg::*; #(
  parameter int NBChannels  = 4,
  parameter int NBChanLog   = 2,
  parameter int CSCntLength = CS_CNT_LENGTH
);
  logic [NBChannels-1:0]             chanEn;
  logic [NBChannels*CSCntLength-1:0] CSCntIn;
  logic [NBChannels-1:0]             CSReqIn;
  logic [NBChannels-1:0]             CSAckOut;
  logic [CSCntLength-1:0]            CSCnt;
  logic                              CSReq;
  logic                              CSAck;
  logic [NBChanLog-1:0]              chanSel;
  logic                              busy;
  logic                              timeout;

  modport master (
    output chanEn, CSCntIn, CSReqIn, CSAck,
    input  CSAckOut, CSCnt, CSReq, chanSel, busy, timeout
  );

  modport slave (
    input  chanEn, CSCntIn, CSReqIn, CSAck,
    output CSAckOut, CSCnt, CSReq, chanSel, busy, timeout
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set bit of req scanning ptr, ptr+1, ...
// modulo N. Purely combinational so other arbiters can reuse it.
module rr_priority_pick #(
  parameter int N    = 4,
  parameter int IdxW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            found,
  output logic [IdxW-1:0] idx
);

  always_comb begin
    int cand;
    // NOTE: defaults first so no path through the loop leaves found/idx unassigned (no latch).
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    // Scan from the farthest offset down so the nearest hit to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        found = 1'b1;
        idx   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/cs_channel_arbiter.sv
// Round-robin arbiter sharing one coherent-sampler consumer between
// NBChannels COSO samplers; all outputs registered.
module cs_channel_arbiter import cs_pkg::*; #(
  parameter int NBChannels  = 4,
  parameter int NBChanLog   = 2,
  parameter int CSCntLength = CS_CNT_LENGTH,
  parameter int TimeoutLog  = 8
) (
  input logic                  clk,
  input logic                  rstN,
  cs_channel_arbiter_if.slave  bus
);

  localparam logic [TimeoutLog-1:0] TIMER_MAX = '1;

  arb_state_t            state;
  logic [NBChanLog-1:0]  rr_ptr;
  logic [TimeoutLog-1:0] timer;
  logic [NBChannels-1:0] eligible;
  logic                  pick_found;
  logic [NBChanLog-1:0]  pick_idx;

  assign eligible = bus.CSReqIn & bus.chanEn;

  rr_priority_pick #(
    .N    (NBChannels),
    .IdxW (NBChanLog)
  ) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      timer        <= '0;
      bus.CSAckOut <= '0;
      bus.CSCnt    <= '0;
      bus.CSReq    <= 1'b0;
      bus.chanSel  <= '0;
      bus.busy     <= 1'b0;
      bus.timeout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block order-independent.
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            bus.CSCnt   <= bus.CSCntIn[pick_idx*CSCntLength +: CSCntLength];
            bus.chanSel <= pick_idx;
            bus.CSReq   <= 1'b1;
            bus.busy    <= 1'b1;
            timer       <= '0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.CSAck) begin
            bus.CSReq              <= 1'b0;
            bus.CSAckOut[bus.chanSel] <= 1'b1;
            state                  <= ST_ACK;
          end else if (timer == TIMER_MAX) begin
            // Release the channel anyway so a dead consumer cannot deadlock it.
            bus.CSReq              <= 1'b0;
            bus.timeout            <= 1'b1;
            bus.CSAckOut[bus.chanSel] <= 1'b1;
            state                  <= ST_ACK;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_ACK: begin
          bus.CSAckOut <= '0;
          state        <= ST_DROP;
        end
        ST_DROP: begin
          // Wait for the request level to fall so it is never granted twice.
          if (!bus.CSReqIn[bus.chanSel]) begin
            rr_ptr   <= NBChanLog'(wrap_inc(int'(bus.chanSel), NBChannels));
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_channel_arbiter.sv
// Randomised and directed bench for cs_channel_arbiter against a
// transaction-level reference model of the arbitration rules.
module tb_cs_channel_arbiter;
  localparam int N    = 4;
  localparam int LOG  = 2;
  localparam int L    = 16;
  localparam int TL   = 4;
  localparam int TMAX = (1 << TL) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_in = '0;
  logic [N-1:0] en = '1;
  logic [L-1:0] cnt_in [N];
  logic         ack = 1'b0;

  cs_channel_arbiter_if #(.NBChannels(N), .NBChanLog(LOG), .CSCntLength(L)) bus ();
  assign bus.chanEn  = en;
  assign bus.CSReqIn = req_in;
  assign bus.CSAck   = ack;
  for (genvar gi = 0; gi < N; gi++) begin : g_cnt
    assign bus.CSCntIn[gi*L +: L] = cnt_in[gi];
  end

  cs_channel_arbiter #(
    .NBChannels (N), .NBChanLog (LOG), .CSCntLength (L), .TimeoutLog (TL)
  ) dut (
    .clk  (clk),
    .rstN (rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the consumer and what phase its transaction is in.
  bit           m_busy, m_in_req, m_in_ack, m_timeout;
  int           m_sel, m_ptr, m_age;
  logic [N-1:0] m_ack_out;
  logic [L-1:0] m_cnt;

  int ch_hold [N];
  int ch_gap  [N];
  bit ch_acked[N];
  int raise_pct, hold_max, ack_pct, stray_pct, cnt_pct, en_pct;

  int g_log[$];
  bit prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_in_req = 0; m_in_ack = 0; m_timeout = 0;
    m_sel = 0; m_ptr = 0; m_age = 0; m_ack_out = '0; m_cnt = '0;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      bit hit = 0;
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (!hit && req_in[c] && en[c]) begin
          hit = 1; m_sel = c; m_cnt = cnt_in[c]; m_age = 0;
          m_busy = 1; m_in_req = 1;
        end
      end
    end else if (m_in_req) begin
      if (ack || m_age == TMAX) begin
        if (!ack) m_timeout = 1;
        m_in_req = 0; m_in_ack = 1; m_ack_out[m_sel] = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_in_ack) begin
      m_in_ack = 0; m_ack_out = '0;
    end else if (!req_in[m_sel]) begin
      m_busy = 0; m_ptr = (m_sel + 1) % N;
    end
  endtask

  task automatic compare_all();
    check("CSReq",    32'(bus.CSReq),    32'(m_in_req));
    check("CSAckOut", 32'(bus.CSAckOut), 32'(m_ack_out));
    check("CSCnt",    32'(bus.CSCnt),    32'(m_cnt));
    check("chanSel",  32'(bus.chanSel),  32'(m_sel));
    check("busy",     32'(bus.busy),     32'(m_busy));
    check("timeout",  32'(bus.timeout),  32'(m_timeout));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    compare_all();
    if (bus.CSReq && !prev_req) g_log.push_back(int'(bus.chanSel));
    prev_req = bus.CSReq;
  endtask

  task automatic clear_channels();
    for (int i = 0; i < N; i++) begin
      ch_hold[i] = 0; ch_gap[i] = 0; ch_acked[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_in = '0; ack = 1'b0; prev_req = 1'b0;
    model_reset(); clear_channels();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Well-behaved samplers: hold until acked, drop after a random hold, stay low >=1 cycle.
  task automatic stim();
    for (int i = 0; i < N; i++) begin
      if (m_ack_out[i]) begin
        ch_acked[i] = 1; ch_hold[i] = int'($urandom_range(0, hold_max));
      end
      if (req_in[i]) begin
        if (ch_acked[i]) begin
          if (ch_hold[i] == 0) begin
            req_in[i] = 1'b0; ch_acked[i] = 0; ch_gap[i] = 1;
          end else begin
            ch_hold[i]--;
          end
        end else if (int'($urandom_range(0, 99)) < cnt_pct) begin
          cnt_in[i] = L'($urandom);
        end
      end else if (ch_gap[i] > 0) begin
        ch_gap[i]--;
      end else if (int'($urandom_range(0, 99)) < raise_pct) begin
        req_in[i] = 1'b1; cnt_in[i] = L'($urandom);
      end
    end
    ack = (m_in_req && int'($urandom_range(0, 99)) < ack_pct) ||
          (int'($urandom_range(0, 99)) < stray_pct);
    if (int'($urandom_range(0, 99)) < en_pct) en = N'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    req_in = '0;
    while (m_busy && n < 100) begin
      ack = m_in_req; tick(); n++;
    end
    ack = 1'b0;
    if (m_busy) bound_fail("drain");
    clear_channels();
  endtask

  task automatic set_knobs(input int r, input int h, input int a, input int s, input int c, input int e);
    raise_pct = r; hold_max = h; ack_pct = a; stray_pct = s; cnt_pct = c; en_pct = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    int exp2[6] = '{0, 1, 2, 3, 0, 1};
    int exp3[4] = '{1, 3, 1, 3};
    for (int i = 0; i < N; i++) cnt_in[i] = '0;

    // Reset state
    do_reset();
    check("rst CSReq", 32'(bus.CSReq), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst CSCnt", 32'(bus.CSCnt), 0);

    // Single channel 2, ack three cycles after CSReq
    en = '1; cnt_in[2] = 16'h1234; req_in = 4'b0100;
    tick();
    check("t1 CSReq", 32'(bus.CSReq), 1);
    check("t1 CSCnt", 32'(bus.CSCnt), 32'h1234);
    check("t1 chanSel", 32'(bus.chanSel), 2);
    tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    check("t1 ackout", 32'(bus.CSAckOut), 32'b0100);
    check("t1 CSReq low", 32'(bus.CSReq), 0);
    req_in = '0; tick();
    check("t1 ack one cycle", 32'(bus.CSAckOut), 0);
    check("t1 busy in drop", 32'(bus.busy), 1);
    tick();
    check("t1 busy low", 32'(bus.busy), 0);

    // All channels requesting continuously
    do_reset();
    set_knobs(100, 0, 100, 0, 0, 0);
    g_log.delete(); n = 0;
    while (g_log.size() < 6 && n < 300) begin stim(); tick(); n++; end
    if (g_log.size() < 6) bound_fail("t2 grants");
    else for (int i = 0; i < 6; i++) begin
      check("t2 grant order", 32'(g_log[i]), 32'(exp2[i]));
      if (i > 0) check("t2 no repeat", 32'(g_log[i] != g_log[i-1]), 1);
    end
    drain();

    // Enable mask 1010
    do_reset();
    en = 4'b1010; g_log.delete(); n = 0;
    while (g_log.size() < 4 && n < 300) begin stim(); tick(); n++; end
    if (g_log.size() < 4) bound_fail("t3 grants");
    else for (int i = 0; i < 4; i++) check("t3 grant order", 32'(g_log[i]), 32'(exp3[i]));
    got = 0; n = 0;
    while (!got && n < 200) begin stim(); tick(); n++; got = m_in_req && m_sel == 1; end
    if (!got) bound_fail("t3 wait ch1");
    en = 4'b1000; got = 0; n = 0;
    while (!got && n < 50) begin stim(); tick(); n++; got = bus.CSAckOut[1]; end
    check("t3 ch1 completes", 32'(got), 1);
    drain(); en = '1;

    // Channel holds its request 10 cycles after ack
    req_in = 4'b1000; n = 0;
    while (!m_in_req && n < 20) begin tick(); n++; end
    ack = 1'b1; tick(); ack = 1'b0;
    check("t5 ackout", 32'(bus.CSAckOut), 32'b1000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5 busy held", 32'(bus.busy), 1);
      check("t5 no regrant", 32'(bus.CSReq), 0);
    end
    req_in = '0; tick();
    check("t5 idle", 32'(bus.busy), 0);

    // Random traffic, responsive consumer
    set_knobs(30, 3, 50, 5, 20, 3);
    for (int i = 0; i < 1500; i++) begin stim(); tick(); end
    drain(); en = '1;

    // Asynchronous reset during REQ
    req_in = 4'b1000; tick(); tick();
    check("t6 in REQ", 32'(bus.CSReq), 1);
    rst_n = 1'b0; #1; model_reset();
    check("t6 CSReq", 32'(bus.CSReq), 0);
    check("t6 CSAckOut", 32'(bus.CSAckOut), 0);
    check("t6 busy", 32'(bus.busy), 0);
    check("t6 timeout", 32'(bus.timeout), 0);
    check("t6 chanSel", 32'(bus.chanSel), 0);
    req_in = 4'b0110; prev_req = 1'b0; tick();
    rst_n = 1'b1; tick();
    check("t6 first grant", 32'(bus.chanSel), 1);
    check("t6 first CSReq", 32'(bus.CSReq), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    drain();

    // Consumer never acks
    check("t4 timeout clear", 32'(bus.timeout), 0);
    req_in = 4'b0011; ack = 1'b0; tick();
    check("t4 grant0", 32'(bus.chanSel), 0);
    n = 1;
    while (bus.CSReq && n < 100) begin tick(); if (bus.CSReq) n++; end
    check("t4 req cycles", 32'(n), 16);
    check("t4 ackout", 32'(bus.CSAckOut), 32'b0001);
    check("t4 timeout set", 32'(bus.timeout), 1);
    req_in[0] = 1'b0; n = 0;
    while (!bus.CSReq && n < 20) begin tick(); n++; end
    check("t4 next grant", 32'(bus.chanSel), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    drain();
    check("t4 timeout sticky", 32'(bus.timeout), 1);

    // Random traffic, slow consumer with stray acks
    set_knobs(40, 6, 8, 10, 30, 5);
    for (int i = 0; i < 2000; i++) begin stim(); tick(); end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
